// File: rtl/decode_stage_sb_pkg.sv
// Shared types and constants for the scoreboarded decode stage: decoded
// instruction record, opcode values and format codes.
package decode_stage_sb_pkg;

    localparam int DEC_DATA_WIDTH = 32;
    localparam int DEC_NUM_REGS   = 32;
    localparam int DEC_RA_W       = $clog2(DEC_NUM_REGS);

    localparam logic [6:0] OPC_LD0  = 7'h10;
    localparam logic [6:0] OPC_LD1  = 7'h11;
    localparam logic [6:0] OPC_ST0  = 7'h12;
    localparam logic [6:0] OPC_ST1  = 7'h13;
    localparam logic [6:0] OPC_BEQ  = 7'h30;
    localparam logic [6:0] OPC_JUMP = 7'h31;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_M = 3'd1;
    localparam logic [2:0] FMT_B = 3'd3;

    typedef struct packed {
        logic [6:0]                opcode;
        logic [DEC_RA_W-1:0]       rd;
        logic                      writes_rd;
        logic                      is_store;
        logic                      is_branch;
        logic [DEC_DATA_WIDTH-1:0] ra_val;
        logic [DEC_DATA_WIDTH-1:0] rb_val;
        logic [DEC_DATA_WIDTH-1:0] imm;
    } dec_info_t;

    function automatic logic is_load(input logic [6:0] opc);
        return (opc == OPC_LD0) || (opc == OPC_LD1);
    endfunction

    function automatic logic is_store_opc(input logic [6:0] opc);
        return (opc == OPC_ST0) || (opc == OPC_ST1);
    endfunction

endpackage

// File: rtl/decode_stage_sb_bypass_mux.sv
// Single-source operand resolver: r0, then youngest matching bypass channel,
// then same-cycle write-back, then the register-file read value.
module dec_bypass_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int RA_W       = 5,
    parameter int NUM_BYP    = 2,
    parameter bit REG0_ZERO  = 1'b1
) (
    input  logic [RA_W-1:0]            src_addr,
    input  logic [NUM_BYP-1:0]         byp_valid,
    input  logic [NUM_BYP*RA_W-1:0]    byp_addr,
    input  logic [NUM_BYP*DATA_WIDTH-1:0] byp_data,
    input  logic                       wb_en,
    input  logic [RA_W-1:0]            wb_addr,
    input  logic [DATA_WIDTH-1:0]      wb_data,
    input  logic [DATA_WIDTH-1:0]      rf_data,
    output logic [DATA_WIDTH-1:0]      value,
    output logic                       covered
);

    // Channels are scanned oldest-first so the lowest index overrides.
    always_comb begin
        value   = rf_data;
        covered = 1'b0;
        if (REG0_ZERO && src_addr == '0) begin
            value   = '0;
            covered = 1'b1;
        end else begin
            if (wb_en && wb_addr == src_addr) begin
                value   = wb_data;
                covered = 1'b1;
            end
            for (int i = NUM_BYP - 1; i >= 0; i--) begin
                if (byp_valid[i] && byp_addr[i*RA_W +: RA_W] == src_addr) begin
                    value   = byp_data[i*DATA_WIDTH +: DATA_WIDTH];
                    covered = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decode_stage_sb.sv
// Decode stage with register file, per-register pending scoreboard and an
// N-channel bypass network; stalls fetch on uncovered RAW/WAW hazards.
module decode_stage_sb
    import decode_stage_sb_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = DEC_DATA_WIDTH,
    parameter int NUM_REGS    = DEC_NUM_REGS,
    parameter int NUM_BYP     = 2,
    parameter bit REG0_ZERO   = 1'b1,
    localparam int RA_W       = $clog2(NUM_REGS)
) (
    input  logic                          clock,
    input  logic                          reset_c,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_WIDTH-1:0]        in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output dec_info_t                     out_info,
    input  logic                          wb_en,
    input  logic [RA_W-1:0]               wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    input  logic [NUM_BYP-1:0]            byp_valid,
    input  logic [NUM_BYP*RA_W-1:0]       byp_addr,
    input  logic [NUM_BYP*DATA_WIDTH-1:0] byp_data,
    input  logic                          flush,
    output logic                          hazard_stall
);

    logic [6:0]            opcode;
    logic [RA_W-1:0]       rd_f;
    logic [RA_W-1:0]       ra_f;
    logic [RA_W-1:0]       src_b;
    logic                  reads_a;
    logic                  reads_b;
    logic                  dec_writes;
    logic                  dec_store;
    logic                  dec_branch;
    logic [DATA_WIDTH-1:0] dec_imm;

    logic [DATA_WIDTH-1:0] a_val;
    logic [DATA_WIDTH-1:0] b_val;
    logic                  a_cov;
    logic                  b_cov;

    logic                  sets_rd;
    logic                  hazard;
    logic                  accept;
    dec_info_t             info_next;

    logic [NUM_REGS-1:0]   sb_q;
    logic [NUM_REGS-1:0]   sb_d;
    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];
    logic                  out_valid_q;
    logic                  out_valid_d;
    dec_info_t             out_info_q;
    dec_info_t             out_info_d;

    // Stores and BEQ carry their second source in the rd field.
    always_comb begin
        opcode     = in_instr[31:25];
        rd_f       = in_instr[20 +: RA_W];
        ra_f       = in_instr[15 +: RA_W];
        src_b      = in_instr[10 +: RA_W];
        reads_a    = 1'b0;
        reads_b    = 1'b0;
        dec_writes = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_imm    = '0;
        case (opcode[6:4])
            FMT_R: begin
                reads_a    = 1'b1;
                reads_b    = 1'b1;
                dec_writes = 1'b1;
            end
            FMT_M: begin
                if (is_load(opcode)) begin
                    reads_a    = 1'b1;
                    dec_writes = 1'b1;
                    dec_imm    = DATA_WIDTH'(in_instr[14:0]);
                end else if (is_store_opc(opcode)) begin
                    reads_a   = 1'b1;
                    reads_b   = 1'b1;
                    src_b     = in_instr[20 +: RA_W];
                    dec_store = 1'b1;
                    dec_imm   = DATA_WIDTH'(in_instr[14:0]);
                end
            end
            FMT_B: begin
                if (opcode == OPC_BEQ) begin
                    reads_a    = 1'b1;
                    reads_b    = 1'b1;
                    src_b      = in_instr[20 +: RA_W];
                    dec_branch = 1'b1;
                    dec_imm    = DATA_WIDTH'({in_instr[24:20], in_instr[9:0]});
                end else if (opcode == OPC_JUMP) begin
                    reads_a    = 1'b1;
                    dec_branch = 1'b1;
                    dec_imm    = DATA_WIDTH'({in_instr[24:20], in_instr[14:0]});
                end
            end
            default: begin
            end
        endcase
    end

    dec_bypass_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .RA_W       (RA_W),
        .NUM_BYP    (NUM_BYP),
        .REG0_ZERO  (REG0_ZERO)
    ) u_mux_a (
        .src_addr  (ra_f),
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rf_data   (rf_q[ra_f]),
        .value     (a_val),
        .covered   (a_cov)
    );

    dec_bypass_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .RA_W       (RA_W),
        .NUM_BYP    (NUM_BYP),
        .REG0_ZERO  (REG0_ZERO)
    ) u_mux_b (
        .src_addr  (src_b),
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rf_data   (rf_q[src_b]),
        .value     (b_val),
        .covered   (b_cov)
    );

    // A pending source is fine if forwarded; a pending rd only if retiring now.
    always_comb begin
        sets_rd = dec_writes && !(REG0_ZERO && rd_f == '0);
        hazard  = (reads_a && sb_q[ra_f] && !a_cov)
               || (reads_b && sb_q[src_b] && !b_cov)
               || (sets_rd && sb_q[rd_f] && !(wb_en && wb_addr == rd_f));
        in_ready     = !reset_c && !hazard && (!out_valid_q || out_ready) && !flush;
        accept       = in_valid && in_ready;
        hazard_stall = in_valid && hazard;
    end

    always_comb begin
        info_next           = '0;
        info_next.opcode    = opcode;
        info_next.rd        = rd_f;
        info_next.writes_rd = dec_writes;
        info_next.is_store  = dec_store;
        info_next.is_branch = dec_branch;
        info_next.ra_val    = reads_a ? a_val : '0;
        info_next.rb_val    = reads_b ? b_val : '0;
        info_next.imm       = dec_imm;
    end

    // Set after clear so a same-cycle retire and re-issue leaves the bit pending.
    always_comb begin
        sb_d = sb_q;
        if (wb_en) begin
            sb_d[wb_addr] = 1'b0;
        end
        if (accept && sets_rd) begin
            sb_d[rd_f] = 1'b1;
        end
        if (flush) begin
            sb_d = '0;
        end

        rf_d = rf_q;
        if (wb_en && !(REG0_ZERO && wb_addr == '0)) begin
            rf_d[wb_addr] = wb_data;
        end

        out_valid_d = out_valid_q;
        out_info_d  = out_info_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_info_d  = info_next;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset_c) begin
        if (reset_c) begin
            sb_q        <= '0;
            rf_q        <= '{default: '0};
            out_valid_q <= 1'b0;
            out_info_q  <= '0;
        end else begin
            sb_q        <= sb_d;
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            out_info_q  <= out_info_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_info  = out_info_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// Directed bench for decode_stage_sb: expected decoded records are queued at
// issue and popped by an independent monitor on each output handshake.
module tb_decode_stage_sb;
    import decode_stage_sb_pkg::*;

    localparam int DW   = 32;
    localparam int RA_W = 5;
    localparam int NB   = 2;

    logic              clock = 1'b0;
    logic              reset_c;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              out_valid;
    logic              out_ready;
    dec_info_t         out_info;
    logic              wb_en;
    logic [RA_W-1:0]   wb_addr;
    logic [DW-1:0]     wb_data;
    logic [NB-1:0]     byp_valid;
    logic [NB*RA_W-1:0] byp_addr;
    logic [NB*DW-1:0]  byp_data;
    logic              flush;
    logic              hazard_stall;

    int        n_vec  = 0;
    int        n_miss = 0;
    dec_info_t exp_q[$];
    dec_info_t mon_exp;
    dec_info_t exp_a;
    dec_info_t exp_b;

    decode_stage_sb dut (
        .clock        (clock),
        .reset_c      (reset_c),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_info     (out_info),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .byp_valid    (byp_valid),
        .byp_addr     (byp_addr),
        .byp_data     (byp_data),
        .flush        (flush),
        .hazard_stall (hazard_stall)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [14:0] low);
        return {opc, rd, ra, low};
    endfunction

    function automatic dec_info_t mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic wr, input logic st, input logic br,
                                     input logic [31:0] ra_v, input logic [31:0] rb_v,
                                     input logic [31:0] imm);
        dec_info_t r;
        r.opcode    = opc;
        r.rd        = rd;
        r.writes_rd = wr;
        r.is_store  = st;
        r.is_branch = br;
        r.ra_val    = ra_v;
        r.rb_val    = rb_v;
        r.imm       = imm;
        return r;
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic v, input logic ordy);
        in_instr  = instr;
        in_valid  = v;
        out_ready = ordy;
    endtask

    task automatic issue(input string name, input logic [31:0] instr, input bit push,
                         input dec_info_t exp);
        applyStimulus(instr, 1'b1, 1'b1);
        if (push) exp_q.push_back(exp);
        @(negedge clock);
        checkOutput({name, "_in_ready"}, 128'(in_ready), 128'(1));
        step();
    endtask

    // Monitor: compare every transferred record against the oldest expectation.
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_output: got %0h, expected no transfer", out_info);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("mon_info", 128'(out_info), 128'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_c   = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        byp_valid = '0;
        byp_addr  = '0;
        byp_data  = '0;
        flush     = 1'b0;

        repeat (2) step();
        @(negedge clock);
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
        checkOutput("rst_out_info", 128'(out_info), 128'(0));
        step();
        reset_c = 1'b0;

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
        step();
        wb_addr = 5'd2; wb_data = 32'd9;
        step();
        wb_en = 1'b0;

        issue("add_r3", enc(7'h00, 5'd3, 5'd1, {5'd2, 10'd0}), 1'b1,
              mk(7'h00, 5'd3, 1, 0, 0, 32'd7, 32'd9, 0));

        byp_valid = 2'b01; byp_addr = {5'd0, 5'd3}; byp_data = {32'h0, 32'h55};
        applyStimulus(enc(7'h00, 5'd6, 5'd3, {5'd1, 10'd0}), 1'b1, 1'b1);
        exp_q.push_back(mk(7'h00, 5'd6, 1, 0, 0, 32'h55, 32'd7, 0));
        @(negedge clock);
        checkOutput("byp_in_ready", 128'(in_ready), 128'(1));
        checkOutput("byp_no_stall", 128'(hazard_stall), 128'(0));
        step();
        byp_valid = '0;

        applyStimulus(enc(7'h00, 5'd8, 5'd3, {5'd2, 10'd0}), 1'b1, 1'b1);
        @(negedge clock);
        checkOutput("raw_stall", 128'(hazard_stall), 128'(1));
        checkOutput("raw_in_ready", 128'(in_ready), 128'(0));
        step();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        exp_q.push_back(mk(7'h00, 5'd8, 1, 0, 0, 32'h11, 32'd9, 0));
        @(negedge clock);
        checkOutput("wb_cover_in_ready", 128'(in_ready), 128'(1));
        checkOutput("wb_cover_stall", 128'(hazard_stall), 128'(0));
        step();
        wb_en = 1'b0;

        byp_valid = 2'b11; byp_addr = {5'd4, 5'd4}; byp_data = {32'hBB, 32'hAA};
        issue("store", enc(7'h12, 5'd4, 5'd1, 15'h0123), 1'b1,
              mk(7'h12, 5'd4, 0, 1, 0, 32'd7, 32'hAA, 32'h123));
        byp_valid = '0;
        issue("st_no_sb", enc(7'h00, 5'd9, 5'd4, {5'd0, 10'd0}), 1'b1,
              mk(7'h00, 5'd9, 1, 0, 0, 0, 0, 0));
        issue("load", enc(7'h10, 5'd10, 5'd2, 15'h7FFF), 1'b1,
              mk(7'h10, 5'd10, 1, 0, 0, 32'd9, 0, 32'h7FFF));
        issue("beq", enc(7'h30, 5'd1, 5'd2, {5'b10101, 10'h3FF}), 1'b1,
              mk(7'h30, 5'd1, 0, 0, 1, 32'd9, 32'd7, 32'h07FF));
        issue("jump", enc(7'h31, 5'd2, 5'd1, 15'h1234), 1'b1,
              mk(7'h31, 5'd2, 0, 0, 1, 32'd7, 0, 32'h11234));
        issue("nop", enc(7'h20, 5'd0, 5'd1, {5'd2, 10'd0}), 1'b1,
              mk(7'h20, 5'd0, 0, 0, 0, 0, 0, 0));

        exp_a = mk(7'h00, 5'd11, 1, 0, 0, 32'd7, 32'd9, 0);
        issue("hold_a", enc(7'h00, 5'd11, 5'd1, {5'd2, 10'd0}), 1'b1, exp_a);
        applyStimulus(enc(7'h00, 5'd12, 5'd2, {5'd1, 10'd0}), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("hold_in_ready", 128'(in_ready), 128'(0));
            checkOutput("hold_valid", 128'(out_valid), 128'(1));
            checkOutput("hold_info", 128'(out_info), 128'(exp_a));
            step();
        end
        exp_b = mk(7'h00, 5'd12, 1, 0, 0, 32'd9, 32'd7, 0);
        out_ready = 1'b1;
        exp_q.push_back(exp_b);
        @(negedge clock);
        checkOutput("release_in_ready", 128'(in_ready), 128'(1));
        step();

        issue("fl_w3", enc(7'h00, 5'd3, 5'd1, {5'd2, 10'd0}), 1'b1,
              mk(7'h00, 5'd3, 1, 0, 0, 32'd7, 32'd9, 0));
        issue("fl_w7", enc(7'h00, 5'd7, 5'd1, {5'd2, 10'd0}), 1'b0,
              mk(7'h00, 5'd7, 1, 0, 0, 32'd7, 32'd9, 0));
        applyStimulus(enc(7'h00, 5'd13, 5'd3, {5'd7, 10'd0}), 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush_in_ready", 128'(in_ready), 128'(0));
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(mk(7'h00, 5'd13, 1, 0, 0, 32'h11, 0, 0));
        @(negedge clock);
        checkOutput("flush_out_valid", 128'(out_valid), 128'(0));
        checkOutput("flush_sb_clear", 128'(in_ready), 128'(1));
        checkOutput("flush_no_stall", 128'(hazard_stall), 128'(0));
        step();

        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h77;
        step();
        wb_en = 1'b0;
        applyStimulus(enc(7'h00, 5'd14, 5'd1, {5'd2, 10'd0}), 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("pre_rst_in_ready", 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        @(negedge clock);
        checkOutput("pre_rst_valid", 128'(out_valid), 128'(1));
        #2;
        reset_c = 1'b1;
        #1;
        checkOutput("async_rst_valid", 128'(out_valid), 128'(0));
        checkOutput("async_rst_info", 128'(out_info), 128'(0));
        checkOutput("async_rst_in_ready", 128'(in_ready), 128'(0));
        step();
        reset_c   = 1'b0;
        out_ready = 1'b1;

        issue("post_rst_read", enc(7'h00, 5'd15, 5'd14, {5'd5, 10'd0}), 1'b1,
              mk(7'h00, 5'd15, 1, 0, 0, 0, 0, 0));
        in_valid = 1'b0;
        repeat (3) step();
        checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
